// File: rtl/dwc_capture_stage.sv
// dwc_capture_stage: captures the result words of two lock-stepped cores and
// presents them as a pair to the DWC comparator. A watchdog flags a core that
// never delivers its word. Writes arriving while the pair is not yet consumed
// are dropped and counted as overruns.
//
// The comparator acknowledge is named release_pair because "release" is a
// reserved word in SystemVerilog.
//
// Optional feature: define DWC_CAPTURE_SEQ_EN to add the seq_id output. seq_id
// counts consumed pairs and is mirrored into data_set[31:16].
module dwc_capture_stage #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int OVR_CNT_W      = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_a,
    input  logic [31:0]          wdata_a,
    input  logic                 wr_b,
    input  logic [31:0]          wdata_b,
    input  logic                 release_pair,
    input  logic                 clear_status,
    output logic [31:0]          data_a,
    output logic [31:0]          data_b,
    output logic [31:0]          data_set,
    output logic                 timeout_irq,
    output logic [1:0]           fault_core,
    output logic                 overrun,
    output logic [OVR_CNT_W-1:0] overrun_cnt
`ifdef DWC_CAPTURE_SEQ_EN
    ,
    output logic [15:0]          seq_id
`endif
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_ONE = TW'(1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PART_A  = 3'd1,
        PART_B  = 3'd2,
        FULL    = 3'd3,
        TIMEOUT = 3'd4
    } state_t;

    state_t                 state_r;
    logic [TW-1:0]          timer_r;
    logic [1:0]             loaded_r;
    logic [15:0]            seq_id_r;

    logic                   ovr_a_s;
    logic                   ovr_b_s;
    logic [1:0]             ovr_inc_s;
    logic [1:0]             new_fault_s;
    logic [OVR_CNT_W-1:0]   cnt_base_s;
    logic [OVR_CNT_W-1:0]   cnt_next_s;
    logic                   ovr_next_s;
    logic [1:0]             fault_next_s;

    // Saturating add of 0..2 overrun events to the counter.
    function automatic logic [OVR_CNT_W-1:0] sat_add(input logic [OVR_CNT_W-1:0] cnt,
                                                     input logic [1:0] inc);
        logic [OVR_CNT_W:0] sum;
        sum = {1'b0, cnt} + (OVR_CNT_W + 1)'(inc);
        if (sum[OVR_CNT_W]) begin
            return {OVR_CNT_W{1'b1}};
        end else begin
            return sum[OVR_CNT_W-1:0];
        end
    endfunction

    // Classify this cycle's strobes as overruns and detect watchdog expiry.
    always_comb begin
        ovr_a_s     = 1'b0;
        ovr_b_s     = 1'b0;
        new_fault_s = 2'b00;
        case (state_r)
            PART_A: begin
                // An abort drops any write in flight, including the missing core's.
                if (release_pair) begin
                    ovr_a_s = wr_a;
                    ovr_b_s = wr_b;
                end else begin
                    ovr_a_s = wr_a;
                    ovr_b_s = 1'b0;
                    if (!wr_b && (timer_r == TIMER_MAX)) begin
                        new_fault_s = 2'b10;
                    end else begin
                        new_fault_s = 2'b00;
                    end
                end
            end
            PART_B: begin
                if (release_pair) begin
                    ovr_a_s = wr_a;
                    ovr_b_s = wr_b;
                end else begin
                    ovr_a_s = 1'b0;
                    ovr_b_s = wr_b;
                    if (!wr_a && (timer_r == TIMER_MAX)) begin
                        new_fault_s = 2'b01;
                    end else begin
                        new_fault_s = 2'b00;
                    end
                end
            end
            FULL: begin
                ovr_a_s = wr_a;
                ovr_b_s = wr_b;
            end
            default: begin
                // IDLE captures everything; TIMEOUT ignores writes without counting.
                ovr_a_s = 1'b0;
                ovr_b_s = 1'b0;
            end
        endcase
        ovr_inc_s = {1'b0, ovr_a_s} + {1'b0, ovr_b_s};
        // A clear in the same cycle as a new event leaves only the new event.
        if (clear_status) begin
            cnt_base_s   = {OVR_CNT_W{1'b0}};
            ovr_next_s   = (ovr_inc_s != 2'd0);
            fault_next_s = new_fault_s;
        end else begin
            cnt_base_s   = overrun_cnt;
            ovr_next_s   = overrun | (ovr_inc_s != 2'd0);
            fault_next_s = fault_core | new_fault_s;
        end
        cnt_next_s = sat_add(cnt_base_s, ovr_inc_s);
    end

    // Sticky status flags and overrun counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun     <= 1'b0;
            overrun_cnt <= {OVR_CNT_W{1'b0}};
            fault_core  <= 2'b00;
        end else begin
            overrun     <= ovr_next_s;
            overrun_cnt <= cnt_next_s;
            fault_core  <= fault_next_s;
        end
    end

    // Capture FSM: slot loading, watchdog timer, release handling, pair sequence.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            timer_r     <= {TW{1'b0}};
            loaded_r    <= 2'b00;
            data_a      <= 32'h0000_0000;
            data_b      <= 32'h0000_0000;
            timeout_irq <= 1'b0;
            seq_id_r    <= 16'h0000;
        end else begin
            timeout_irq <= 1'b0;
            case (state_r)
                IDLE: begin
                    timer_r <= {TW{1'b0}};
                    if (wr_a && wr_b) begin
                        data_a   <= wdata_a;
                        data_b   <= wdata_b;
                        loaded_r <= 2'b11;
                        state_r  <= FULL;
                    end else if (wr_a) begin
                        data_a   <= wdata_a;
                        loaded_r <= 2'b01;
                        state_r  <= PART_A;
                    end else if (wr_b) begin
                        data_b   <= wdata_b;
                        loaded_r <= 2'b10;
                        state_r  <= PART_B;
                    end else begin
                        loaded_r <= 2'b00;
                    end
                end
                PART_A, PART_B: begin
                    if (release_pair) begin
                        loaded_r <= 2'b00;
                        timer_r  <= {TW{1'b0}};
                        state_r  <= IDLE;
                    end else if ((state_r == PART_A) && wr_b) begin
                        data_b   <= wdata_b;
                        loaded_r <= 2'b11;
                        timer_r  <= {TW{1'b0}};
                        state_r  <= FULL;
                    end else if ((state_r == PART_B) && wr_a) begin
                        data_a   <= wdata_a;
                        loaded_r <= 2'b11;
                        timer_r  <= {TW{1'b0}};
                        state_r  <= FULL;
                    end else if (timer_r == TIMER_MAX) begin
                        timeout_irq <= 1'b1;
                        timer_r     <= {TW{1'b0}};
                        state_r     <= TIMEOUT;
                    end else begin
                        timer_r <= timer_r + TIMER_ONE;
                    end
                end
                FULL: begin
                    if (release_pair) begin
                        loaded_r <= 2'b00;
                        seq_id_r <= seq_id_r + 16'd1;
                        state_r  <= IDLE;
                    end else begin
                        loaded_r <= 2'b11;
                    end
                end
                TIMEOUT: begin
                    if (release_pair) begin
                        loaded_r <= 2'b00;
                        state_r  <= IDLE;
                    end else begin
                        state_r  <= TIMEOUT;
                    end
                end
                default: begin
                    loaded_r <= 2'b00;
                    timer_r  <= {TW{1'b0}};
                    state_r  <= IDLE;
                end
            endcase
        end
    end

`ifdef DWC_CAPTURE_SEQ_EN
    assign seq_id   = seq_id_r;
    assign data_set = {seq_id_r, 14'd0, loaded_r};
`else
    assign data_set = {30'd0, loaded_r};
`endif

endmodule

// File: tb/tb_dwc_capture_stage.sv
// Scoreboard bench for dwc_capture_stage (TIMEOUT_CYCLES = 8, OVR_CNT_W = 8).
module tb_dwc_capture_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_a = 1'b0;
    logic [31:0] wdata_a = 32'h0;
    logic        wr_b = 1'b0;
    logic [31:0] wdata_b = 32'h0;
    logic        rel = 1'b0;
    logic        clear_status = 1'b0;
    logic [31:0] data_a;
    logic [31:0] data_b;
    logic [31:0] data_set;
    logic        timeout_irq;
    logic [1:0]  fault_core;
    logic        overrun;
    logic [7:0]  overrun_cnt;
`ifdef DWC_CAPTURE_SEQ_EN
    logic [15:0] seq_id;
`endif

    dwc_capture_stage #(.TIMEOUT_CYCLES(8), .OVR_CNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .wr_a(wr_a), .wdata_a(wdata_a), .wr_b(wr_b), .wdata_b(wdata_b),
        .release_pair(rel), .clear_status(clear_status),
        .data_a(data_a), .data_b(data_b), .data_set(data_set),
        .timeout_irq(timeout_irq), .fault_core(fault_core),
        .overrun(overrun), .overrun_cnt(overrun_cnt)
`ifdef DWC_CAPTURE_SEQ_EN
        , .seq_id(seq_id)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] set;
        logic        irq;
        logic [1:0]  fault;
        logic        ovr;
        logic [7:0]  cnt;
        logic [15:0] seq;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    int n_vec = 0;
    int n_err = 0;

    // Expected architectural state, maintained by the test sequence.
    logic [31:0] ea = 32'h0;
    logic [31:0] eb = 32'h0;
    logic [1:0]  efault = 2'b00;
    logic        eovr = 1'b0;
    logic [7:0]  ecnt = 8'h00;
    logic [15:0] eseq = 16'h0000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus and queue the outputs expected after its edge.
    task automatic cyc(input logic wa, input logic [31:0] da, input logic wb,
                       input logic [31:0] db, input logic r, input logic clr,
                       input logic rst, input logic [1:0] eset, input logic eirq);
        exp_t e;
        wr_a = wa; wdata_a = da; wr_b = wb; wdata_b = db;
        rel = r; clear_status = clr; reset = rst;
        e.a = ea; e.b = eb; e.irq = eirq; e.fault = efault;
        e.ovr = eovr; e.cnt = ecnt; e.seq = eseq;
`ifdef DWC_CAPTURE_SEQ_EN
        e.set = {eseq, 14'd0, eset};
`else
        e.set = {30'd0, eset};
`endif
        @(posedge clk);
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input logic [1:0] eset, input logic eirq);
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, eset, eirq);
    endtask

    // Compare DUT outputs against the oldest queued expectation, away from the edge.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            chk("data_a", data_a, mon_e.a);
            chk("data_b", data_b, mon_e.b);
            chk("data_set", data_set, mon_e.set);
            chk("timeout_irq", {31'd0, timeout_irq}, {31'd0, mon_e.irq});
            chk("fault_core", {30'd0, fault_core}, {30'd0, mon_e.fault});
            chk("overrun", {31'd0, overrun}, {31'd0, mon_e.ovr});
            chk("overrun_cnt", {24'd0, overrun_cnt}, {24'd0, mon_e.cnt});
`ifdef DWC_CAPTURE_SEQ_EN
            chk("seq_id", {16'd0, seq_id}, {16'd0, mon_e.seq});
`endif
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0);

        // A first, B three cycles later, then release
        ea = 32'h1234_5678;
        cyc(1'b1, 32'h1234_5678, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0);
        idle(2'b01, 1'b0);
        idle(2'b01, 1'b0);
        eb = 32'h1234_5678;
        cyc(1'b0, 32'h0, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0);
        idle(2'b11, 1'b0);
        eseq = eseq + 16'd1;
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        idle(2'b00, 1'b0);

        // Simultaneous writes go straight to FULL
        ea = 32'hAAAA_5555; eb = 32'hAAAA_5554;
        cyc(1'b1, 32'hAAAA_5555, 1'b1, 32'hAAAA_5554, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0);
        eseq = eseq + 16'd1;
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);

        // Core B never arrives: timeout 8 cycles after entering PART_A
        ea = 32'h0000_CAFE;
        cyc(1'b1, 32'h0000_CAFE, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0);
        for (int i = 0; i < 7; i++) idle(2'b01, 1'b0);
        efault = 2'b10;
        idle(2'b01, 1'b1);
        cyc(1'b0, 32'h0, 1'b1, 32'h0000_BEEF, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        efault = 2'b00;
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0);

        // Missing write on the last allowed cycle wins over timeout
        ea = 32'h0000_0010;
        cyc(1'b1, 32'h0000_0010, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0);
        for (int i = 0; i < 7; i++) idle(2'b01, 1'b0);
        eb = 32'h0000_0020;
        cyc(1'b0, 32'h0, 1'b1, 32'h0000_0020, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0);

        // Overruns in FULL; first one coincides with clear_status
        eovr = 1'b1; ecnt = 8'd1;
        cyc(1'b1, 32'h0000_0099, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 2'b11, 1'b0);
        ecnt = 8'd2;
        cyc(1'b1, 32'h0000_0099, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0);
        ecnt = 8'd3;
        cyc(1'b1, 32'h0000_0099, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0);
        eovr = 1'b0; ecnt = 8'd0;
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 2'b11, 1'b0);

        // Release with a concurrent write: release wins, write counted
        eovr = 1'b1; ecnt = 8'd1; eseq = eseq + 16'd1;
        cyc(1'b0, 32'h0, 1'b1, 32'h0000_0077, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);

        // Double-strobe overruns count 2 each and saturate at 255
        ea = 32'h0000_0001; eb = 32'h0000_0002;
        cyc(1'b1, 32'h0000_0001, 1'b1, 32'h0000_0002, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0);
        for (int i = 0; i < 130; i++) begin
            ecnt = (1 + 2 * (i + 1) > 255) ? 8'd255 : 8'(1 + 2 * (i + 1));
            cyc(1'b1, 32'h0000_00F0, 1'b1, 32'h0000_00F1, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0);
        end
        eseq = eseq + 16'd1;
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);

        // Reset while in PART_B clears everything
        eb = 32'h0000_0055;
        cyc(1'b0, 32'h0, 1'b1, 32'h0000_0055, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0);
        ea = 32'h0; eb = 32'h0; efault = 2'b00; eovr = 1'b0; ecnt = 8'd0; eseq = 16'h0;
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
        idle(2'b00, 1'b0);

        @(negedge clk);
        chk("sb_drain", sb_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dwc_capture_stage.md
Name: dwc_capture_stage

Overview:
- Upstream feeder for the duplicate-with-compare (DWC) comparator.
- Captures the 32-bit result word written independently by core A and core B MicroBlaze instances.
- Presents the pair as data_a/data_b with a per-core loaded mask on data_set (3 = both loaded).
- Watchdogs the lagging core, raising a timeout interrupt if one core never delivers, and flags writes that arrive before the previous pair is released.

Parameters:
- TIMEOUT_CYCLES, 1000, cycles allowed between first and second core write before declaring timeout (min 2).
- OVR_CNT_W, 8, width of saturating overrun counter.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- wr_a  in  1  single-cycle write strobe from core A.
- wdata_a  in  32  core A result word.
- wr_b  in  1  single-cycle write strobe from core B.
- wdata_b  in  32  core B result word.
- release  in  1  level from MB (comparator ack); pair consumed, clear capture.
- clear_status  in  1  pulse; clears sticky fault_core, overrun, overrun_cnt.
- data_a  out  32  captured core A word to comparator.
- data_b  out  32  captured core B word to comparator.
- data_set  out  32  bit0 = A loaded, bit1 = B loaded, bits 31:2 = 0.
- timeout_irq  out  1  one-cycle pulse on timeout.
- fault_core  out  2  sticky missing-core mask (01 = A missing, 10 = B missing).
- overrun  out  1  sticky, write hit an already-loaded slot.
- overrun_cnt  out  OVR_CNT_W  saturating count of overrun events.

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE, timer 0.
- Registered outputs. A write accepted at edge N is visible on data_x/data_set after edge N (1-cycle latency).
- States:
  - IDLE: data_set = 0.
    - wr_a only -> PART_A (capture A).
    - wr_b only -> PART_B.
    - Both -> FULL (capture both).
    - release ignored.
  - PART_A / PART_B: timer increments each cycle from 0.
    - Write of the missing core -> FULL, timer cleared.
    - Timer == TIMEOUT_CYCLES-1 with no missing write -> TIMEOUT. Missing write on that same cycle wins (go FULL).
    - release -> IDLE, data_set cleared (abort).
  - FULL: data_set = 3, held until release = 1 -> IDLE with data_set = 0 on the next edge. data_a/data_b keep last values.
  - TIMEOUT:
    - On entry: timeout_irq = 1 for exactly one cycle, fault_core |= missing mask.
    - data_set keeps the partial mask; writes are ignored and not counted.
    - release -> IDLE.
- Overrun:
  - A write to a slot whose data_set bit is already 1 (PART_x same core, FULL, either) is not captured.
  - overrun set to 1; overrun_cnt += 1 per offending strobe, saturating at all-ones.
  - Both strobes offending in one cycle count as 2.
- release coinciding with a write in FULL or PART_x:
  - release has priority; state -> IDLE.
  - The write is dropped and counted as overrun.
- clear_status concurrent with a new overrun/timeout: the new event wins (flag set, count = 1).
- Reset mid-operation returns to IDLE next edge and discards any partial pair.

Optional Feature:
- Macro: DWC_CAPTURE_SEQ_EN.
- When defined:
  - Adds output seq_id[15:0], reset 0.
  - seq_id increments (wrapping 0xFFFF -> 0) on each FULL -> IDLE release, identifying the pair currently presented.
  - data_set bits 31:16 carry seq_id.
- When undefined:
  - No seq_id port.
  - data_set bits 31:2 are 0.

Test Plan:
- wr_a with wdata_a = 0x12345678 @cycle 0, then wr_b with wdata_b = 0x12345678 @cycle 3 -> data_set = 1 after cycle 0, 3 after cycle 3; data_a = data_b = 0x12345678; release -> data_set = 0 next cycle.
- wr_a and wr_b same cycle (0xAAAA5555, 0xAAAA5554) -> data_set goes 0 -> 3 directly; both words captured.
- wr_a only, TIMEOUT_CYCLES = 8 -> timeout_irq pulses once 8 cycles after entering PART_A; fault_core = 10; a late wr_b is ignored; release -> IDLE, data_set = 0.
- In FULL, wr_a three times -> overrun = 1, overrun_cnt = 3, data_a unchanged; clear_status -> both 0.
- release and wr_b same cycle in FULL -> IDLE, data_set = 0, overrun_cnt = 1; reset asserted in PART_B -> all outputs 0 next edge.
- With DWC_CAPTURE_SEQ_EN: 3 full pair/release cycles -> seq_id = 3 and data_set[31:16] = 3; preload seq_id 0xFFFF -> wraps to 0 on release.
